// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divider: state encoding, default width and
// the divide-by-zero result fill.
package hilo_div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Quotient is all ones on divide-by-zero; every bit takes this value.
    localparam logic DIV_ZERO_FILL = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StEnd     = 2'd2,
        StEndZero = 2'd3
    } div_state_e;

endpackage

// File: rtl/hilo_div_unit_if.sv
// Execute-stage / register-file side of the divider: launch operands, stall,
// and the HI/LO write port.
interface hilo_div_unit_if
    import hilo_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             start_i;
    logic             signed_i;
    logic             annul_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             stall_o;
    logic             done_o;
    logic             hi_we;
    logic [WIDTH-1:0] hi_o;
    logic             lo_we;
    logic [WIDTH-1:0] lo_o;

    modport slave (
        input  start_i, signed_i, annul_i, dividend_i, divisor_i,
        output stall_o, done_o, hi_we, hi_o, lo_we, lo_o
    );

    modport master (
        output start_i, signed_i, annul_i, dividend_i, divisor_i,
        input  stall_o, done_o, hi_we, hi_o, lo_we, lo_o
    );
endinterface

// File: rtl/hilo_div_unit_div_core_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in the quotient bit.
module hilo_div_unit_div_core_step
    import hilo_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             q_bit;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign q_bit   = (shifted >= {1'b0, divisor_i});
    // When the subtraction fits, the true difference is below 2^WIDTH, so the
    // truncated subtract of the low bits is exact.
    assign sub     = shifted[WIDTH-1:0] - divisor_i;

    always_comb begin
        rem_o = shifted[WIDTH-1:0];
        if (q_bit) begin
            rem_o = sub;
        end
        quo_o = {quo_i[WIDTH-2:0], q_bit};
    end
endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; drives the HI/LO write
// port with remainder on HI and quotient on LO.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic             clk,
    input logic             rst,
    hilo_div_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] lo_fix_d;
    logic [WIDTH-1:0] hi_fix_d;

    assign dvd_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
    assign dvs_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
    assign dvd_mag = dvd_neg ? -bus.dividend_i : bus.dividend_i;
    assign dvs_mag = dvs_neg ? -bus.divisor_i : bus.divisor_i;

    hilo_div_unit_div_core_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Sign fix-up applied to the final iteration's result on entry to StEnd.
    assign lo_fix_d = q_neg_q ? -step_quo : step_quo;
    assign hi_fix_d = r_neg_q ? -step_rem : step_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.divisor_i == '0) begin
                            state_q <= StEndZero;
                            done_q  <= 1'b1;
                            hi_q    <= bus.dividend_i;
                            lo_q    <= {WIDTH{DIV_ZERO_FILL}};
                        end else begin
                            state_q <= StRun;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            q_neg_q <= dvd_neg ^ dvs_neg;
                            r_neg_q <= dvd_neg;
                        end
                    end
                end
                StRun: begin
                    if (bus.annul_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            state_q <= StEnd;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            lo_q    <= lo_fix_d;
                            hi_q    <= hi_fix_d;
                        end
                    end
                end
                StEnd, StEndZero: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall is released on the writeback cycle so the pipeline advances with it.
    assign bus.stall_o = ~rst & ((state_q == StRun) |
                                 ((state_q == StIdle) & bus.start_i & ~bus.annul_i));
    assign bus.done_o  = done_q;
    assign bus.hi_we   = done_q;
    assign bus.lo_we   = done_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed and randomized DIV/DIVU
// against an arithmetic reference, plus annul, ignored start and reset cases.
module tb_hilo_div_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hilo_div_unit_if #(.WIDTH(W)) dif ();

    hilo_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return $urandom_range(0, 20);
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dif.start_i    = 1'b0;
        dif.annul_i    = 1'b0;
        dif.signed_i   = $urandom_range(0, 1);
        dif.dividend_i = $urandom;
        dif.divisor_i  = $urandom;
    endtask

    // Launches one op in the current cycle and records what the DUT does.
    // Returns with the current cycle being the one after done, so a following
    // call starts back-to-back.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output int done_cyc, output logic [31:0] lo, output logic [31:0] hi,
                          output logic [63:0] stall_hist, output bit we_ok, output bit post_done);
        done_cyc   = -1;
        lo         = '0;
        hi         = '0;
        stall_hist = '0;
        we_ok      = 1'b0;
        dif.start_i    = 1'b1;
        dif.annul_i    = 1'b0;
        dif.signed_i   = s;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            stall_hist[c] = dif.stall_o;
            if (dif.done_o === 1'b1) begin
                done_cyc = c;
                lo       = dif.lo_o;
                hi       = dif.hi_o;
                we_ok    = (dif.hi_we === 1'b1) && (dif.lo_we === 1'b1);
            end
            tick();
            if (c == 0) idle_inputs();
            if (done_cyc >= 0) break;
        end
        #3;
        post_done = (dif.done_o !== 1'b0) || (dif.hi_we !== 1'b0) || (dif.lo_we !== 1'b0);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        dif.start_i    = 1'b1;
        dif.annul_i    = 1'b0;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'h1234;
        dif.divisor_i  = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({dif.stall_o, dif.done_o, dif.hi_we, dif.lo_we} !== 4'b0) begin
                failures++;
                $display("FAIL reset_ctrl: got stall/done/hi_we/lo_we=%b want 0000",
                         {dif.stall_o, dif.done_o, dif.hi_we, dif.lo_we});
            end
            checks++;
            if (dif.hi_o !== 32'h0 || dif.lo_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_data: got hi=%h lo=%h want 0 0", dif.hi_o, dif.lo_o);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_1234,
                                32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFF0};
        logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0};
        bit ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] eq, er, lo, hi;
        logic [63:0] hist, mask;
        int dc, d;
        bit we_ok, post;
        for (int i = 0; i < 7; i++) begin
            ref_div(ta[i], tb[i], ts[i], eq, er);
            d    = (tb[i] == 0) ? 1 : W + 1;
            mask = (64'd1 << d) - 64'd1;
            run_op(ta[i], tb[i], ts[i], dc, lo, hi, hist, we_ok, post);
            checks++;
            if (dc != d) begin
                failures++;
                $display("FAIL dir%0d_done_cycle: got %0d want %0d", i, dc, d);
            end
            checks++;
            if (lo !== eq || hi !== er) begin
                failures++;
                $display("FAIL dir%0d_result: got lo=%h hi=%h want lo=%h hi=%h",
                         i, lo, hi, eq, er);
            end
            checks++;
            if (hist !== mask) begin
                failures++;
                $display("FAIL dir%0d_stall: got %h want %h", i, hist, mask);
            end
            checks++;
            if (!we_ok || post) begin
                failures++;
                $display("FAIL dir%0d_we_pulse: got we_ok=%0b post=%0b want 1 0", i, we_ok, post);
            end
            last_lo = eq;
            last_hi = er;
        end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] a, b, eq, er, lo, hi;
        logic [63:0] hist;
        int dc, d;
        bit s, we_ok, post;
        for (int i = 0; i < 25; i++) begin
            a = rnd_operand();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_operand();
            s = $urandom_range(0, 1);
            ref_div(a, b, s, eq, er);
            d = (b == 0) ? 1 : W + 1;
            run_op(a, b, s, dc, lo, hi, hist, we_ok, post);
            checks++;
            if (dc != d || lo !== eq || hi !== er || !we_ok || post) begin
                failures++;
                $display("FAIL rnd%0d %h/%h s=%0b: got cyc=%0d lo=%h hi=%h we=%0b post=%0b want cyc=%0d lo=%h hi=%h",
                         i, a, b, s, dc, lo, hi, we_ok, post, d, eq, er);
            end
            last_lo = eq;
            last_hi = er;
        end
    endtask

    task automatic test_annul();
        logic [31:0] a, b, eq, er, lo, hi;
        logic [63:0] hist;
        int dc;
        bit we_ok, post, saw_done, stall10, stall11;
        saw_done       = 1'b0;
        dif.start_i    = 1'b1;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd50;
        dif.divisor_i  = 32'd5;
        for (int c = 0; c <= 11; c++) begin
            if (c == 10) dif.annul_i = 1'b1;
            @(negedge clk);
            if (dif.done_o !== 1'b0 || dif.hi_we !== 1'b0 || dif.lo_we !== 1'b0) saw_done = 1'b1;
            if (c == 10) stall10 = dif.stall_o;
            if (c == 11) stall11 = dif.stall_o;
            tick();
            if (c == 0) dif.start_i = 1'b0;
            if (c == 10) dif.annul_i = 1'b0;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL annul_no_write: got a done/we pulse want none");
        end
        checks++;
        if (stall10 !== 1'b1 || stall11 !== 1'b0) begin
            failures++;
            $display("FAIL annul_stall: got c10=%b c11=%b want 1 0", stall10, stall11);
        end
        checks++;
        if (dif.hi_o !== last_hi || dif.lo_o !== last_lo) begin
            failures++;
            $display("FAIL annul_hold: got hi=%h lo=%h want hi=%h lo=%h",
                     dif.hi_o, dif.lo_o, last_hi, last_lo);
        end
        // Cycle 12: a fresh operation must run its full length.
        a = $urandom;
        b = $urandom_range(1, 1000);
        ref_div(a, b, 1'b0, eq, er);
        run_op(a, b, 1'b0, dc, lo, hi, hist, we_ok, post);
        checks++;
        if (dc != W + 1 || lo !== eq || hi !== er) begin
            failures++;
            $display("FAIL annul_restart: got cyc=%0d lo=%h hi=%h want cyc=%0d lo=%h hi=%h",
                     dc, lo, hi, W + 1, eq, er);
        end
        last_lo = eq;
        last_hi = er;
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, eq, er, lo, hi;
        int dc;
        a = $urandom;
        b = $urandom_range(2, 50000);
        ref_div(a, b, 1'b1, eq, er);
        dc = -1;
        dif.start_i    = 1'b1;
        dif.signed_i   = 1'b1;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (dif.done_o === 1'b1) begin
                dc = c;
                lo = dif.lo_o;
                hi = dif.hi_o;
            end
            tick();
            if (c == 0) idle_inputs();
            if (c == 4) begin
                dif.start_i    = 1'b1;
                dif.signed_i   = 1'b0;
                dif.dividend_i = ~a;
                dif.divisor_i  = b + 32'd3;
            end
            if (c == 5) idle_inputs();
            if (dc >= 0) break;
        end
        checks++;
        if (dc != W + 1) begin
            failures++;
            $display("FAIL ignore_start_cycle: got %0d want %0d", dc, W + 1);
        end
        checks++;
        if (lo !== eq || hi !== er) begin
            failures++;
            $display("FAIL ignore_start_result: got lo=%h hi=%h want lo=%h hi=%h", lo, hi, eq, er);
        end
        last_lo = eq;
        last_hi = er;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done       = 1'b0;
        dif.start_i    = 1'b1;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd1000;
        dif.divisor_i  = 32'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 0) idle_inputs();
        end
        rst = 1'b1;
        tick();
        dif.start_i = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.hi_o !== 32'h0 || dif.lo_o !== 32'h0 ||
            {dif.stall_o, dif.done_o, dif.hi_we, dif.lo_we} !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got hi=%h lo=%h ctrl=%b want 0 0 0000",
                     dif.hi_o, dif.lo_o, {dif.stall_o, dif.done_o, dif.hi_we, dif.lo_we});
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dif.done_o !== 1'b0 || dif.hi_we !== 1'b0 || dif.lo_we !== 1'b0) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done || dif.hi_o !== 32'h0 || dif.lo_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_no_write: got done_seen=%0b hi=%h lo=%h want 0 0 0",
                     saw_done, dif.hi_o, dif.lo_o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_annul();
        test_ignore_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle radix-2 restoring divider that executes MIPS DIV/DIVU and acts as the writer side of the register file's HI/LO write port.
- Accepts one operation from the execute stage and stalls the pipeline while busy.
- On completion, pulses hi_we/lo_we for one cycle with remainder on hi_o and quotient on lo_o.
- Outputs wire directly to the register file inputs hi_we, hi_i, lo_we and lo_i.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start_i  in  1  launch request; sampled only in IDLE.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- annul_i  in  1  cancel in-flight operation (exception/flush).
- dividend_i  in  WIDTH  rs operand; sampled with start_i.
- divisor_i  in  WIDTH  rt operand; sampled with start_i.
- stall_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle result-valid pulse.
- hi_we  out  1  HI write enable; equals done_o.
- hi_o  out  WIDTH  remainder.
- lo_we  out  1  LO write enable; equals done_o.
- lo_o  out  WIDTH  quotient.

Behaviour:
- Reset: state IDLE, counter 0; stall_o, done_o, hi_we, lo_we, hi_o and lo_o all 0. rst overrides every other input, including mid-operation; no write is issued.
- States:
  - IDLE: start_i=1 and annul_i=0 -> if divisor_i==0 then END_ZERO, else RUN.
  - RUN: one quotient bit per cycle for WIDTH cycles, counter 0..WIDTH-1. After the last iteration -> END. annul_i=1 -> IDLE immediately, with no write and outputs unchanged.
  - END / END_ZERO: done_o=hi_we=lo_we=1 for exactly one cycle, then -> IDLE. annul_i in END is ignored; the result is committed.
- Timing, cycle 0 = start_i high in IDLE:
  - Iterations occur in cycles 1..WIDTH.
  - done pulses in cycle WIDTH+1 (33).
  - For divide-by-zero, done pulses in cycle 1.
- stall_o:
  - Combinational in IDLE: start_i & ~annul_i.
  - 1 throughout RUN.
  - 0 in END and END_ZERO, so the pipeline advances on the writeback cycle.
- Signed handling:
  - At start, take magnitudes of both operands and record quotient sign (sign(dividend) ^ sign(divisor)) and remainder sign (sign(dividend)).
  - At END, negate the quotient and/or remainder accordingly; magnitude arithmetic is WIDTH+1 bits.
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (decided values): lo_o = all ones, hi_o = dividend_i as sampled (unsigned or signed alike).
- hi_o/lo_o are registered; they update only on entry to END/END_ZERO and hold until the next completion or reset.
- start_i outside IDLE is ignored; no queuing.
- start_i and annul_i high together in IDLE: annul wins and no operation starts.

Decomposition:
- Shared package/defines header: state encodings (IDLE, RUN, END, END_ZERO), DIV_WIDTH = 32, divide-by-zero result constant.
- One sub-module is natural: div_core_step, the combinational single-iteration restoring subtract/shift (partial remainder, quotient bit in; updated pair out).
- The FSM, counter, sign fix-up and output registers stay in the top module.

Test Plan:
1. DIVU 100 / 7: start in cycle 0 -> stall_o=1 cycles 0..32; done/hi_we/lo_we=1 only in cycle 33 with lo_o=14, hi_o=2; stall_o=0 in cycle 33.
2. DIV -7 / 2 (0xFFFFFFF9, 2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF at cycle 33. DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
3. DIVU 0x1234 / 0 -> done in cycle 1 with lo_o=0xFFFFFFFF, hi_o=0x1234; stall_o=1 only in cycle 0.
4. Start 50/5, assert annul_i in cycle 10 -> IDLE in cycle 11, no done/hi_we/lo_we pulse, hi_o/lo_o keep prior values. A new start in cycle 12 completes normally in cycle 45.
5. Start, then pulse start_i again in cycle 5 with different operands -> ignored, original result delivered in cycle 33. rst in cycle 20 of a new operation -> all outputs 0, no write.
6. DIVU 0xFFFFFFFF / 1 and DIVU 3 / 0xFFFFFFFF -> (lo,hi) = (0xFFFFFFFF, 0) and (0, 3) respectively.
